spi_counter_reader: RTL
=======================

Name: spi_counter_reader

Overview:
- SPI mode-0 master that reads the frequency-measurement board over its SPI slave port.
- On each `start` it runs one 80-bit frame, MSB first: 40-bit counter_not, then 40-bit counter_etalon.
- It presents both values as parallel registers with a one-cycle valid strobe.
- It sits on the host/test FPGA and drives SCLK, CS and MOSI to the slave, sampling MISO.

Parameters:
- WIDTH, 40, bit width of each counter; frame length is 2*WIDTH.
- CLK_DIV, 6, system clocks per SCLK half-period (≥2); 12 MHz / (2*6) gives 1 MHz SCLK.
- CMD, 8'hA5, command byte shifted out on MOSI in the first 8 SCLK cycles; MOSI is 0 afterwards.
- CS_GAP, 4, minimum CS-high time after a frame, in SCLK half-periods.

Ports:
- clk_12MHz  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle request to read one frame.
- o_busy  out  1  high from the cycle after `start` is accepted until return to IDLE.
- o_SPI_CLK  out  1  SCLK, idle low (CPOL=0).
- o_SPI_CS  out  1  chip select, active low, idle high.
- o_SPI_MOSI  out  1  master data out.
- i_SPI_MISO  in  1  slave data in.
- o_counter_not  out  WIDTH  first WIDTH bits received.
- o_counter_etalon  out  WIDTH  second WIDTH bits received.
- o_valid  out  1  one-cycle pulse when both counters update.

Behaviour:
Reset (async assert, sync deassert inside the block):
- CS=1, SCLK=0, MOSI=0, busy=0, valid=0.
- Both counter outputs = 0; shift register and bit counter cleared; state IDLE.
- Reset mid-frame aborts immediately with CS high. No partial data reaches the outputs.

States:
- IDLE: CS=1, SCLK=0. `i_start`=1 → SETUP. At the next edge CS=0, busy=1, MOSI = CMD[7], half-period counter loaded with CLK_DIV-1.
- SETUP: holds CLK_DIV cycles (CS-to-first-edge setup), then → XFER.
- XFER: SCLK toggles each time the half-period counter expires.
  - Rising edge: sample i_SPI_MISO into the LSB of an internal 2*WIDTH shift register; increment the bit count.
  - Falling edge: drive the next MOSI bit (CMD[6..0], then 0).
  - After the rising edge with bit count = 2*WIDTH, wait the remaining half-period, drive SCLK low → HOLD.
- HOLD: SCLK=0 for CLK_DIV cycles, then:
  - CS=1.
  - o_counter_not = shift[2*WIDTH-1:WIDTH].
  - o_counter_etalon = shift[WIDTH-1:0].
  - o_valid=1 for exactly one cycle.
  - → GAP.
- GAP: CS=1 for CS_GAP*CLK_DIV cycles, then → IDLE; busy drops on the IDLE entry edge.

Timing and rules:
- o_valid rises exactly 1 + CLK_DIV*(2 + 4*WIDTH) cycles after the cycle in which start was sampled. That is 973 cycles at the defaults.
- `i_start` while busy is ignored and not queued.
- `i_start` held high restarts only after GAP completes.
- Counter outputs hold their last value between frames and change only with o_valid.
- SCLK high and low phases are each exactly CLK_DIV cycles; there is no glitch on abort.
- MISO is sampled directly, since SCLK is generated from clk_12MHz and the slave returns data half a period ahead.

Test Plan:
1. Slave model returns 40'h0102030405 then 40'h1122334455, start pulsed once → after 973 cycles o_valid=1 for one cycle, o_counter_not=40'h0102030405, o_counter_etalon=40'h1122334455.
2. Same frame, monitor pins → exactly 80 SCLK rising edges while CS=0, each high/low phase 6 cycles, MOSI bits on the first 8 edges = 1010_0101 then 0.
3. Pulse start again at cycle 100 of a frame → no effect; exactly one o_valid; the next start after busy falls yields a second correct frame.
4. Assert i_rst_n=0 after 30 SCLK edges → CS=1 and SCLK=0 asynchronously, outputs 0, no o_valid; after release a new start completes normally.
5. start held high continuously → CS-high gap between frames ≥ 24 cycles; consecutive frames are identical and correct.
6. Slave returns all-ones then all-zeros → counter_not=40'hFF_FFFF_FFFF, counter_etalon=0 (checks MSB/LSB boundary and no bit slip).

Source files
------------

// File: rtl/spi_counter_reader_if.sv
// Host-side pins of the SPI counter reader: start/busy/valid handshake,
// the SPI master pins, and the two parallel counter results.
interface spi_counter_reader_if #(
  parameter int unsigned WIDTH = 40
);
  logic             i_start;
  logic             o_busy;
  logic             o_SPI_CLK;
  logic             o_SPI_CS;
  logic             o_SPI_MOSI;
  logic             i_SPI_MISO;
  logic [WIDTH-1:0] o_counter_not;
  logic [WIDTH-1:0] o_counter_etalon;
  logic             o_valid;

  modport master (
    input  i_start, i_SPI_MISO,
    output o_busy, o_SPI_CLK, o_SPI_CS, o_SPI_MOSI,
    output o_counter_not, o_counter_etalon, o_valid
  );

  modport slave (
    output i_start, i_SPI_MISO,
    input  o_busy, o_SPI_CLK, o_SPI_CS, o_SPI_MOSI,
    input  o_counter_not, o_counter_etalon, o_valid
  );
endinterface

// File: rtl/spi_counter_reader.sv
// SPI mode-0 master: one 2*WIDTH-bit read per start, MSB first, split into
// counter_not (first half) and counter_etalon (second half) with a valid strobe.
module spi_counter_reader #(
  parameter int unsigned WIDTH   = 40,
  parameter int unsigned CLK_DIV = 6,
  parameter logic [7:0]  CMD     = 8'hA5,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic                 clk_12MHz,
  input  logic                 i_rst_n,
  spi_counter_reader_if.master bus
);
  localparam int unsigned FRAME   = 2 * WIDTH;
  localparam int unsigned GAP_CYC = CS_GAP * CLK_DIV;
  localparam int unsigned CNT_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(FRAME + 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  // Reset asserts asynchronously but releases two clocks later, in step with clk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk_12MHz or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bits_q, bits_d;
  logic [FRAME-1:0]   shift_q, shift_d;
  logic               sclk_q, sclk_d;
  logic               cs_q, cs_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   not_q, not_d;
  logic [WIDTH-1:0]   et_q, et_d;
  logic               expired;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    not_d   = not_q;
    et_d    = et_q;
    expired = (cnt_q == '0);

    if (state_q != IDLE && !expired) cnt_d = cnt_q - CNT_W'(1);

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        cs_d   = 1'b1;
        if (bus.i_start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = CMD[7];
          cnt_d   = CNT_W'(CLK_DIV - 1);
          bits_d  = '0;
          shift_d = '0;
        end
      end
      SETUP: begin
        if (expired) begin
          state_d = XFER;
          cnt_d   = CNT_W'(CLK_DIV - 1);
        end
      end
      XFER: begin
        if (expired) begin
          cnt_d = CNT_W'(CLK_DIV - 1);
          if (!sclk_q) begin
            // Slave shifts on the falling edge, so MISO is settled at our rise.
            sclk_d  = 1'b1;
            shift_d = {shift_q[FRAME-2:0], bus.i_SPI_MISO};
            bits_d  = bits_q + BIT_W'(1);
          end else begin
            sclk_d = 1'b0;
            mosi_d = (bits_q < BIT_W'(8)) ? CMD[3'd7 - bits_q[2:0]] : 1'b0;
            if (bits_q == BIT_W'(FRAME)) begin
              state_d = HOLD;
              cnt_d   = CNT_W'(CLK_DIV - 1);
            end
          end
        end
      end
      HOLD: begin
        if (expired) begin
          state_d = GAP;
          cs_d    = 1'b1;
          not_d   = shift_q[FRAME-1:WIDTH];
          et_d    = shift_q[WIDTH-1:0];
          valid_d = 1'b1;
          cnt_d   = CNT_W'(GAP_CYC - 1);
        end
      end
      GAP: begin
        if (expired) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      not_q   <= '0;
      et_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      not_q   <= not_d;
      et_q    <= et_d;
    end
  end

  assign bus.o_busy           = busy_q;
  assign bus.o_SPI_CLK        = sclk_q;
  assign bus.o_SPI_CS         = cs_q;
  assign bus.o_SPI_MOSI       = mosi_q;
  assign bus.o_valid          = valid_q;
  assign bus.o_counter_not    = not_q;
  assign bus.o_counter_etalon = et_q;
endmodule
